vga_stream_out: RTL and testbench
=================================

// Module: vga_stream_out
// PURPOSE
//  Parametrised VGA output stage: generates raster timing from one system clock
//  and drains a valid/ready pixel stream with start-of-packet framing into VGA_*
//  pins. Replaces the fixed 640x480 system-generated VGA core behind the board
//  top level; resolution, colour depth, pixel-clock divide and sync polarity are
//  parameters. Adds stream resynchronisation and an underflow flag.
// PARAMETERS
//  COLOR_BITS 8   bits per colour channel on pix_data (1..8)
//  CLK_DIV    2   clk cycles per pixel (>=2); 50 MHz/2 = 25 MHz
//  H_ACTIVE   640 visible pixels per line
//  H_FP 16, H_SYNC 96, H_BP 48   horizontal porch/sync widths in pixels
//  V_ACTIVE   480 visible lines
//  V_FP 10, V_SYNC 2, V_BP 33    vertical porch/sync widths in lines
//  HS_POL     0   1 = hsync active-high, 0 = active-low; VS_POL likewise for vsync
// PORTS
//  clk        in   1             system clock (50 MHz)
//  reset      in   1             synchronous, active-high
//  pix_data   in   3*COLOR_BITS  {R,G,B}, R in MSBs
//  pix_sop    in   1             beat is pixel (0,0) of a frame
//  pix_valid  in   1             beat valid
//  pix_ready  out  1             beat accepted when valid&ready at a clk edge
//  vga_clk    out  1             pixel clock to DAC
//  vga_hs, vga_vs out 1          syncs, polarity per HS_POL/VS_POL
//  vga_blank  out  1             active-low blank (0 outside visible area)
//  vga_sync   out  1             constant 0
//  vga_r/g/b  out  8 each        colour, 0 while blanked
//  underflow  out  1             1-clk pulse per resync event
// BEHAVIOUR
//  - div_cnt 0..CLK_DIV-1; pe=1 when div_cnt==CLK_DIV-1. vga_clk registered:
//    0 for div_cnt<CLK_DIV/2, else 1. Pixel outputs update on the pe edge only.
//  - H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; h_cnt 0..H_TOTAL-1 wraps on pe; v_cnt
//    advances on h wrap, wraps at V_TOTAL. Counter widths $clog2(total).
//  - hs asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vs likewise.
//    active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
//  - All of hs/vs/blank/rgb registered together: one pixel period latency from
//    counters; never skewed against each other.
//  - Colour expansion: each COLOR_BITS channel widened to 8 by MSB replication
//    (e.g. 4'hA -> 8'hAA; COLOR_BITS=1: 1 -> 8'hFF).
//  - FSM:
//    SEEK:   pix_ready = !(pix_valid&&pix_sop); non-SOP beats dropped every clk;
//            valid SOP seen -> ARMED (beat left unconsumed). Output black.
//    ARMED:  pix_ready=0 until pe at h=0,v=0 -> ACTIVE (consume SOP that cycle).
//    ACTIVE: pix_ready = pe && active. At active pe: valid && !sop (or sop at
//            origin) -> display beat. !valid -> black pixel, underflow, -> SEEK.
//            valid && sop away from origin -> not consumed, black, underflow, ->
//            SEEK. At origin, valid && !sop -> not consumed, underflow, -> SEEK.
//  - SEEK/ARMED always output black during active area; syncs never stop.
//  - Reset (any cycle, mid-frame included): counters 0, state SEEK, pix_ready 0,
//    vga_clk 0, hs/vs inactive level, vga_blank 0, rgb 0, underflow 0. First
//    frame after reset starts at origin on first pe.
// CONFIGURATION
//  VGA_TEST_PATTERN_EN defined: extra input pattern_sel[1:0]; when !=0, stream
//  path ignored (pix_ready=0, FSM held in SEEK, no underflow) and active area
//  shows 1=8 vertical colour bars (H_ACTIVE/8 wide, order white,yellow,cyan,
//  green,magenta,red,blue,black), 2=h_cnt[7:0] grey ramp, 3=solid 8'hFF white.
//  Not defined: no pattern_sel port, no pattern logic; stream only.
// TESTING
//  1 Reset held 3 clk mid-line -> hs/vs inactive, blank 0, rgb 0, ready 0;
//    after release h_cnt 0 at first pe, vga_clk period = CLK_DIV clk.
//  2 Small timing (H 8/1/2/1, V 4/1/1/1, CLK_DIV 2): hs low exactly pixels 9-10
//    of 12, vs low exactly line 5 of 7, blank 0 outside 8x4 window.
//  3 Full 32-beat frame, SOP on beat 0, COLOR_BITS 4, beat k = {k,k,k} ->
//    pixel k shows rgb {kk,kk,kk}; ready high only at active pe; no underflow.
//  4 Drop valid at pixel 5 -> pixel 5 black, one underflow pulse, ready pattern
//    SEEK; next SOP displayed from next frame origin, frame intact.
//  5 Stream starts with 3 non-SOP beats then SOP -> 3 beats dropped in 3 clk,
//    SOP pixel appears at origin, zero underflow.
//  6 VGA_TEST_PATTERN_EN, pattern_sel=1, H_ACTIVE 8 -> pixel 0 FFFFFF,
//    pixel 5 FF0000, pixel 7 000000; pix_ready stays 0.

Source files
------------

// File: rtl/vga_stream_out.sv
// vga_stream_out: parametrised VGA raster generator that drains a valid/ready
// pixel stream with start-of-packet framing onto the VGA pins. The stream is
// resynchronised to the frame origin whenever it falls out of step with the
// raster. Optional build macro VGA_TEST_PATTERN_EN adds a pattern_sel input and
// built-in colour bar / grey ramp / white test patterns.
module vga_stream_out #(
  parameter int   COLOR_BITS = 8,
  parameter int   CLK_DIV    = 2,
  parameter int   H_ACTIVE   = 640,
  parameter int   H_FP       = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BP       = 48,
  parameter int   V_ACTIVE   = 480,
  parameter int   V_FP       = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BP       = 33,
  parameter logic HS_POL     = 1'b0,
  parameter logic VS_POL     = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3*COLOR_BITS-1:0] pix_data,
  input  logic                    pix_sop,
  input  logic                    pix_valid,
  output logic                    pix_ready,
`ifdef VGA_TEST_PATTERN_EN
  input  logic [1:0]              pattern_sel,
`endif
  output logic                    vga_clk,
  output logic                    vga_hs,
  output logic                    vga_vs,
  output logic                    vga_blank,
  output logic                    vga_sync,
  output logic [7:0]              vga_r,
  output logic [7:0]              vga_g,
  output logic [7:0]              vga_b,
  output logic                    underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {SEEK, ARMED, ACTIVE} state_t;

  logic [DW-1:0] div_cnt_reg, div_cnt_next;
  logic          pe;
  logic          vga_clk_reg;
  logic [HW-1:0] h_cnt_reg;
  logic [VW-1:0] v_cnt_reg;
  logic          h_last, v_last;
  logic          hs_on, vs_on, active, at_origin;
  state_t        state_reg, state_next;
  logic          ready_c, show_beat, uf_event;
  logic [7:0]    exp_r, exp_g, exp_b;
  logic [7:0]    r_next, g_next, b_next;
  logic          hs_reg, vs_reg, blank_reg, uf_reg;
  logic [7:0]    r_reg, g_reg, b_reg;

  assign pe           = (div_cnt_reg == DW'(CLK_DIV - 1));
  assign div_cnt_next = pe ? '0 : div_cnt_reg + DW'(1);

  // Pixel-clock divider; vga_clk follows the divider phase so outputs change on its falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_reg <= '0;
      vga_clk_reg <= 1'b0;
    end else begin
      div_cnt_reg <= div_cnt_next;
      vga_clk_reg <= (div_cnt_next >= DW'(CLK_DIV / 2));
    end
  end

  assign h_last = (h_cnt_reg == HW'(H_TOTAL - 1));
  assign v_last = (v_cnt_reg == VW'(V_TOTAL - 1));

  // Raster counters advance once per pixel period.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (pe) begin
      h_cnt_reg <= h_last ? '0 : h_cnt_reg + HW'(1);
      if (h_last) v_cnt_reg <= v_last ? '0 : v_cnt_reg + VW'(1);
    end
  end

  assign hs_on     = (h_cnt_reg >= HW'(H_ACTIVE + H_FP)) && (h_cnt_reg < HW'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_on     = (v_cnt_reg >= VW'(V_ACTIVE + V_FP)) && (v_cnt_reg < VW'(V_ACTIVE + V_FP + V_SYNC));
  assign active    = (h_cnt_reg < HW'(H_ACTIVE)) && (v_cnt_reg < VW'(V_ACTIVE));
  assign at_origin = (h_cnt_reg == '0) && (v_cnt_reg == '0);

  // Widen each channel to 8 bits by repeating its bit pattern from the MSB down.
  for (genvar gi = 0; gi < 8; gi++) begin : g_expand
    localparam int SRC = COLOR_BITS - 1 - ((7 - gi) % COLOR_BITS);
    assign exp_r[gi] = pix_data[2*COLOR_BITS + SRC];
    assign exp_g[gi] = pix_data[COLOR_BITS + SRC];
    assign exp_b[gi] = pix_data[SRC];
  end

`ifdef VGA_TEST_PATTERN_EN
  logic       pattern_on;
  logic [2:0] bar_idx;
  logic [2:0] bar_rgb;
  logic [7:0] grey;

  assign pattern_on = (pattern_sel != 2'd0);
  assign bar_idx    = 3'(h_cnt_reg / HW'(H_ACTIVE / 8));
  assign grey       = 8'(h_cnt_reg);

  // Bar order white, yellow, cyan, green, magenta, red, blue, black as {R,G,B} on/off.
  always_comb begin
    bar_rgb = 3'b000;
    case (bar_idx)
      3'd0: bar_rgb = 3'b111;
      3'd1: bar_rgb = 3'b110;
      3'd2: bar_rgb = 3'b011;
      3'd3: bar_rgb = 3'b010;
      3'd4: bar_rgb = 3'b101;
      3'd5: bar_rgb = 3'b100;
      3'd6: bar_rgb = 3'b001;
      default: bar_rgb = 3'b000;
    endcase
  end
`endif

  // Stream state register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= SEEK;
    else       state_reg <= state_next;
  end

  // Resync FSM: hunt for SOP, wait for the origin, then consume one beat per active pixel.
  always_comb begin
    state_next = state_reg;
    ready_c    = 1'b0;
    show_beat  = 1'b0;
    uf_event   = 1'b0;
    case (state_reg)
      SEEK: begin
        ready_c = !(pix_valid && pix_sop);
        if (pix_valid && pix_sop) state_next = ARMED;
      end
      ARMED, ACTIVE: begin
        // ARMED only takes part from the origin pixel onward.
        if (pe && active && (state_reg == ACTIVE || at_origin)) begin
          ready_c = (pix_sop == at_origin);
          if (pix_valid && (pix_sop == at_origin)) begin
            show_beat  = 1'b1;
            state_next = ACTIVE;
          end else begin
            uf_event   = 1'b1;
            state_next = SEEK;
          end
        end
      end
      default: state_next = SEEK;
    endcase
`ifdef VGA_TEST_PATTERN_EN
    if (pattern_on) begin
      state_next = SEEK;
      ready_c    = 1'b0;
      show_beat  = 1'b0;
      uf_event   = 1'b0;
    end
`endif
  end

  assign pix_ready = ready_c && !reset;

  // Colour for the current pixel: stream beat, test pattern or black.
  always_comb begin
    r_next = 8'h00;
    g_next = 8'h00;
    b_next = 8'h00;
    if (show_beat) begin
      r_next = exp_r;
      g_next = exp_g;
      b_next = exp_b;
    end
`ifdef VGA_TEST_PATTERN_EN
    if (pattern_on && active) begin
      case (pattern_sel)
        2'd1: begin
          r_next = {8{bar_rgb[2]}};
          g_next = {8{bar_rgb[1]}};
          b_next = {8{bar_rgb[0]}};
        end
        2'd2: begin
          r_next = grey;
          g_next = grey;
          b_next = grey;
        end
        default: begin
          r_next = 8'hFF;
          g_next = 8'hFF;
          b_next = 8'hFF;
        end
      endcase
    end
`endif
  end

  // Syncs, blank and colour registered together on the pixel edge so they never skew.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_reg    <= ~HS_POL;
      vs_reg    <= ~VS_POL;
      blank_reg <= 1'b0;
      r_reg     <= 8'h00;
      g_reg     <= 8'h00;
      b_reg     <= 8'h00;
      uf_reg    <= 1'b0;
    end else begin
      uf_reg <= uf_event;
      if (pe) begin
        hs_reg    <= hs_on ? HS_POL : ~HS_POL;
        vs_reg    <= vs_on ? VS_POL : ~VS_POL;
        blank_reg <= active;
        r_reg     <= r_next;
        g_reg     <= g_next;
        b_reg     <= b_next;
      end
    end
  end

  assign vga_clk   = vga_clk_reg;
  assign vga_hs    = hs_reg;
  assign vga_vs    = vs_reg;
  assign vga_blank = blank_reg;
  assign vga_sync  = 1'b0;
  assign vga_r     = r_reg;
  assign vga_g     = g_reg;
  assign vga_b     = b_reg;
  assign underflow = uf_reg;

endmodule

// File: tb/tb_vga_stream_out.sv
// Directed bench for vga_stream_out on a tiny 8x4 raster (H 8/1/2/1, V 4/1/1/1,
// CLK_DIV 2, 4-bit colour). Global pixel P has its pixel edge at clock 2P+2
// after reset release; inputs for it are driven at 2P+1, outputs read at 2P+2.
module tb_vga_stream_out;

  logic        clk;
  logic        reset;
  logic [11:0] pix_data;
  logic        pix_sop;
  logic        pix_valid;
  logic        pix_ready;
  logic        vga_clk, vga_hs, vga_vs, vga_blank, vga_sync;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        underflow;
`ifdef VGA_TEST_PATTERN_EN
  logic [1:0]  pattern_sel;
`endif

  vga_stream_out #(
    .COLOR_BITS(4), .CLK_DIV(2),
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk(clk), .reset(reset),
    .pix_data(pix_data), .pix_sop(pix_sop), .pix_valid(pix_valid), .pix_ready(pix_ready),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank(vga_blank), .vga_sync(vga_sync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int uf_cnt   = 0;

  logic [11:0] src_data [0:127];
  logic        src_sop  [0:127];
  int          src_n    = 0;
  int          src_idx  = 0;
  bit          src_en   = 1'b0;
  int          hole_cyc = -1;

  // Count underflow pulses (each lasts exactly one clock).
  always @(negedge clk) if (underflow === 1'b1) uf_cnt++;

  function automatic logic [11:0] beat(input int kind, input int k);
    logic [3:0] q;
    q = 4'(k);
    case (kind)
      0:       beat = {q, q, q};
      1:       beat = {q, ~q, 4'h3};
      2:       beat = {4'h5, q, ~q};
      default: beat = {~q, 4'h0, q};
    endcase
  endfunction

  function automatic logic [23:0] widen(input logic [11:0] d);
    widen = {d[11:8], d[11:8], d[7:4], d[7:4], d[3:0], d[3:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_assert++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, req);
    end
  endtask

  task automatic drive_src();
    if (src_en && src_idx < src_n && cyc != hole_cyc) begin
      pix_valid = 1'b1;
      pix_data  = src_data[src_idx];
      pix_sop   = src_sop[src_idx];
    end else begin
      pix_valid = 1'b0;
      pix_data  = 12'h000;
      pix_sop   = 1'b0;
    end
  endtask

  task automatic tick();
    logic acc;
    #1;
    acc = pix_valid && pix_ready;
    @(negedge clk);
    cyc++;
    if (acc) src_idx++;
    drive_src();
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic load_frame(input int base, input int kind);
    for (int k = 0; k < 32; k++) begin
      src_data[base + k] = beat(kind, k);
      src_sop[base + k]  = (k == 0);
    end
  endtask

  // Walk a whole frame checking ready at each pixel edge and the registered pixel after it.
  task automatic check_frame(input int f, input int kind, input string tag);
    int pp, h, v;
    logic act;
    for (int p = 0; p < 84; p++) begin
      pp  = f * 84 + p;
      h   = p % 12;
      v   = p / 12;
      act = (h < 8) && (v < 4);
      goto(2 * pp + 1);
      check({tag, "_ready_pe"}, pix_ready, act);
      goto(2 * pp + 2);
      check({tag, "_ready_idle"}, pix_ready, 1'b0);
      check({tag, "_blank"}, vga_blank, act);
      check({tag, "_rgb"}, {vga_r, vga_g, vga_b}, act ? widen(beat(kind, v * 8 + h)) : 24'h0);
      $display("%s pixel h=%0d v=%0d rgb=%06h", tag, h, v, {vga_r, vga_g, vga_b});
    end
  endtask

  initial begin
    int h, v;
    reset     = 1'b1;
    pix_data  = 12'h000;
    pix_sop   = 1'b0;
    pix_valid = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
    pattern_sel = 2'd0;
`endif
    tick(); tick();
    reset = 1'b0;
    repeat (25) tick();

    // Reset asserted mid-line for three clocks.
    reset = 1'b1;
    repeat (3) tick();
    check("rst_hs", vga_hs, 1'b1);
    check("rst_vs", vga_vs, 1'b1);
    check("rst_blank", vga_blank, 1'b0);
    check("rst_rgb", {vga_r, vga_g, vga_b}, 24'h0);
    check("rst_ready", pix_ready, 1'b0);
    check("rst_vga_clk", vga_clk, 1'b0);
    check("rst_underflow", underflow, 1'b0);
    $display("reset held 3 clk: hs=%b vs=%b blank=%b", vga_hs, vga_vs, vga_blank);
    reset  = 1'b0;
    cyc    = 0;
    uf_cnt = 0;

    // Pixel clock phase and raster timing over one idle frame.
    goto(1);
    check("vga_clk_c1", vga_clk, 1'b1);
    for (int p = 0; p < 84; p++) begin
      h = p % 12;
      v = p / 12;
      goto(2 * p + 2);
      if (p < 2) begin
        check("vga_clk_lo", vga_clk, 1'b0);
      end
      check("t_hs", vga_hs, (h == 9 || h == 10) ? 1'b0 : 1'b1);
      check("t_vs", vga_vs, (v == 5) ? 1'b0 : 1'b1);
      check("t_blank", vga_blank, (h < 8) && (v < 4));
      check("t_rgb", {vga_r, vga_g, vga_b}, 24'h0);
      if (p < 2) begin
        goto(2 * p + 3);
        check("vga_clk_hi", vga_clk, 1'b1);
        check("seek_ready_idle", pix_ready, 1'b1);
      end
      $display("timing pixel h=%0d v=%0d hs=%b vs=%b blank=%b", h, v, vga_hs, vga_vs, vga_blank);
    end

    // Full 32-beat frame with SOP on beat 0.
    load_frame(0, 0);
    src_n = 32; src_idx = 0; hole_cyc = -1; src_en = 1'b1;
    drive_src(); #1;
    check("seek_sop_ready", pix_ready, 1'b0);
    check_frame(1, 0, "frame");
    check("frame_underflow", uf_cnt, 0);
    check("frame_consumed", src_idx, 32);

    // Frame A loses valid at pixel 5; frame B follows and must display intact.
    load_frame(0, 1);
    load_frame(32, 2);
    src_n = 64; src_idx = 0; hole_cyc = 2 * (168 + 5) + 1;
    drive_src(); #1;
    for (int p = 0; p < 8; p++) begin
      goto(2 * (168 + p) + 2);
      check("gap_rgb", {vga_r, vga_g, vga_b}, (p < 5) ? widen(beat(1, p)) : 24'h0);
      if (p == 5) begin
        check("gap_underflow", underflow, 1'b1);
        check("gap_seek_ready", pix_ready, 1'b1);
        goto(2 * (168 + p) + 3);
        check("gap_underflow_end", underflow, 1'b0);
      end
      $display("gap pixel %0d rgb=%06h underflow=%b", p, {vga_r, vga_g, vga_b}, underflow);
    end
    goto(503);
    check("gap_drained", src_idx, 32);
    check("gap_armed_ready", pix_ready, 1'b0);
    check_frame(3, 2, "resync");
    check("resync_underflow", uf_cnt, 1);
    check("resync_consumed", src_idx, 64);

    // Reset again, then a stream led by three non-SOP beats.
    reset = 1'b1;
    repeat (3) tick();
    reset  = 1'b0;
    cyc    = 0;
    uf_cnt = 0;
    src_data[0] = 12'hF0F; src_sop[0] = 1'b0;
    src_data[1] = 12'hF0F; src_sop[1] = 1'b0;
    src_data[2] = 12'hF0F; src_sop[2] = 1'b0;
    load_frame(3, 3);
    src_n = 35; src_idx = 0; hole_cyc = -1; src_en = 1'b1;
    drive_src(); #1;
    check("lead_ready", pix_ready, 1'b1);
    goto(2);
    check("lead_black", {vga_r, vga_g, vga_b}, 24'h0);
    goto(3);
    check("lead_dropped", src_idx, 3);
    check("lead_sop_ready", pix_ready, 1'b0);
    check_frame(1, 3, "lead");
    check("lead_underflow", uf_cnt, 0);

`ifdef VGA_TEST_PATTERN_EN
    // Colour bars override the stream.
    pattern_sel = 2'd1;
    for (int p = 0; p < 8; p++) begin
      goto(2 * (168 + p) + 1);
      check("pat_ready", pix_ready, 1'b0);
      goto(2 * (168 + p) + 2);
      if (p == 0) check("pat_px0", {vga_r, vga_g, vga_b}, 24'hFFFFFF);
      if (p == 5) check("pat_px5", {vga_r, vga_g, vga_b}, 24'hFF0000);
      if (p == 7) check("pat_px7", {vga_r, vga_g, vga_b}, 24'h000000);
      $display("pattern pixel %0d rgb=%06h", p, {vga_r, vga_g, vga_b});
    end
    check("pat_underflow", uf_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
